// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only panel engine: power-up wait, fixed init sequence, then
// per-byte setup / EN pulse / hold / execution-wait timing behind a valid/ready port.
module lcd_hd44780_ctrl #(
  parameter int T_PWRUP_CYC = 750000,
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_CLEAR_CYC = 82000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       req_ready_o,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);

  localparam int T_M1  = (T_PWRUP_CYC > T_SETUP_CYC) ? T_PWRUP_CYC : T_SETUP_CYC;
  localparam int T_M2  = (T_EN_CYC > T_HOLD_CYC) ? T_EN_CYC : T_HOLD_CYC;
  localparam int T_M3  = (T_EXEC_CYC > T_CLEAR_CYC) ? T_EXEC_CYC : T_CLEAR_CYC;
  localparam int T_M12 = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int T_MAX = (T_M12 > T_M3) ? T_M12 : T_M3;
  localparam int CW    = $clog2(T_MAX + 1);

  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;

  if (T_PWRUP_CYC < 1 || T_SETUP_CYC < 1 || T_EN_CYC < 1 ||
      T_HOLD_CYC < 1 || T_EXEC_CYC < 1 || T_CLEAR_CYC < 1) begin : g_bad_timing
    $error("lcd_hd44780_ctrl: every T_*_CYC parameter must be >= 1");
  end

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    init_idx;
  logic          is_clear;
  logic          last_cnt;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // Clear display / return home need the long execution wait.
  assign is_clear = !lcd_rs_o && (lcd_data_o[7:2] == 6'd0) && (lcd_data_o != 8'h00);
  assign last_cnt = (cnt == CW'(1));
  assign lcd_rw_o = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_PWRUP;
      cnt         <= '0;
      init_idx    <= 2'd0;
      req_ready_o <= 1'b0;
      init_done_o <= 1'b0;
      lcd_data_o  <= 8'h00;
      lcd_rs_o    <= 1'b0;
      lcd_en_o    <= 1'b0;
      lcd_on_o    <= 1'b0;
    end else begin
      lcd_on_o <= 1'b1;
      case (state)
        ST_PWRUP: begin
          // Counter comes out of reset at 0, so the first edge itself counts.
          if (last_cnt || (cnt == '0 && T_PWRUP_CYC == 1)) begin
            lcd_data_o <= init_byte(2'd0);
            lcd_rs_o   <= 1'b0;
            init_idx   <= 2'd0;
            state      <= ST_SETUP;
            cnt        <= CW'(T_SETUP_CYC);
          end else if (cnt == '0) begin
            cnt <= CW'(T_PWRUP_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            lcd_rs_o    <= req_rs_i;
            lcd_data_o  <= req_data_i;
            req_ready_o <= 1'b0;
            state       <= ST_SETUP;
            cnt         <= CW'(T_SETUP_CYC);
          end
        end
        ST_SETUP: begin
          if (last_cnt) begin
            state    <= ST_PULSE;
            cnt      <= CW'(T_EN_CYC);
            lcd_en_o <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_PULSE: begin
          if (last_cnt) begin
            state    <= ST_HOLD;
            cnt      <= CW'(T_HOLD_CYC);
            lcd_en_o <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (last_cnt) begin
            state <= ST_WAIT;
            cnt   <= is_clear ? CW'(T_CLEAR_CYC) : CW'(T_EXEC_CYC);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_WAIT: begin
          if (last_cnt) begin
            if (!init_done_o && init_idx != 2'd3) begin
              init_idx   <= init_idx + 2'd1;
              lcd_data_o <= init_byte(init_idx + 2'd1);
              lcd_rs_o   <= 1'b0;
              state      <= ST_SETUP;
              cnt        <= CW'(T_SETUP_CYC);
            end else begin
              init_done_o <= 1'b1;
              req_ready_o <= 1'b1;
              state       <= ST_IDLE;
              cnt         <= '0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state       <= ST_PWRUP;
          cnt         <= '0;
          req_ready_o <= 1'b0;
          lcd_en_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: expected panel bytes are queued by the
// stimulus and checked by a monitor on every EN rising edge.
module tb_lcd_hd44780_ctrl;

  localparam int T_PWRUP = 20;
  localparam int T_SETUP = 1;
  localparam int T_EN    = 3;
  localparam int T_HOLD  = 1;
  localparam int T_EXEC  = 5;
  localparam int T_CLEAR = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] lcd_data;

  lcd_hd44780_ctrl #(
    .T_PWRUP_CYC(T_PWRUP), .T_SETUP_CYC(T_SETUP), .T_EN_CYC(T_EN),
    .T_HOLD_CYC(T_HOLD), .T_EXEC_CYC(T_EXEC), .T_CLEAR_CYC(T_CLEAR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_rs_i(req_rs),
    .req_data_i(req_data), .req_ready_o(req_ready), .init_done_o(init_done),
    .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw),
    .lcd_en_o(lcd_en), .lcd_on_o(lcd_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_n = 0;
  int   acc_cyc = 0;
  int   rise_cyc = 0;
  int   rw_err = 0;
  logic en_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Edge counter and handshake log; cyc is the number of the edge just taken.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) begin
      acc_n   <= acc_n + 1;
      acc_cyc <= cyc + 1;
      chk("accept_only_after_init", int'(init_done), 1);
    end
  end

  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_err++;
    if (lcd_en && !en_prev) begin
      if (exp_q.size() == 0) begin
        chk("en_pulse_unexpected", {23'd0, lcd_rs, lcd_data}, -1);
      end else begin
        e = exp_q.pop_front();
        chk("en_rs_data", {23'd0, lcd_rs, lcd_data}, {23'd0, e.rs, e.data});
        if (e.gap != 0) chk("en_rise_gap", cyc - rise_cyc, e.gap);
      end
      rise_cyc = cyc;
    end
    if (!lcd_en && en_prev && rst_n) chk("en_high_width", cyc - rise_cyc, T_EN);
    en_prev = lcd_en;
  end

  task automatic release_and_init(output int rel);
    @(negedge clk);
    exp_q.push_back(exp_t'{1'b0, 8'h38, 0});
    exp_q.push_back(exp_t'{1'b0, 8'h0C, 10});
    exp_q.push_back(exp_t'{1'b0, 8'h01, 10});
    exp_q.push_back(exp_t'{1'b0, 8'h06, 15});
    rst_n = 1'b1;
    rel = cyc;
    for (int i = 0; i < 200 && !init_done; i++) @(negedge clk);
    chk("init_done_edge", cyc - rel, 65);
    chk("ready_with_init_done", int'(req_ready), 1);
    chk("lcd_on_after_release", int'(lcd_on), 1);
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int at);
    int n0;
    req_rs = rs;
    req_data = d;
    req_valid = 1'b1;
    exp_q.push_back(exp_t'{rs, d, 0});
    n0 = acc_n;
    for (int i = 0; i < 300 && acc_n == n0; i++) @(negedge clk);
    chk("accepted_once", acc_n - n0, 1);
    at = acc_cyc;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
  endtask

  initial begin
    int rel, a, a1, a2, a3, a4, a5;
    #12;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_on", int'(lcd_on), 0);

    release_and_init(rel);

    @(negedge clk);
    send(1'b1, 8'h41, a);
    chk("ready_low_after_accept", int'(req_ready), 0);
    chk("latched_rs", int'(lcd_rs), 1);
    chk("latched_data", int'(lcd_data), 8'h41);
    req_valid = 1'b0;
    wait_ready();
    chk("ready_return_cycles", cyc - a, 10);
    chk("en_rise_after_accept", rise_cyc - a, 1);

    // Request held across reset and init.
    @(negedge clk);
    rst_n = 1'b0;
    req_rs = 1'b1;
    req_data = 8'h55;
    req_valid = 1'b1;
    #1 chk("held_rst_ready", int'(req_ready), 0);
    release_and_init(rel);
    exp_q.push_back(exp_t'{1'b1, 8'h55, 0});
    a = acc_n;
    for (int i = 0; i < 20 && acc_n == a; i++) @(negedge clk);
    chk("held_accept_edge", acc_cyc - rel, 66);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("held_single_pulse", exp_q.size(), 0);

    // Back-to-back with valid held; clear command stretches the next accept.
    wait_ready();
    send(1'b1, 8'h48, a1);
    send(1'b1, 8'h49, a2);
    chk("b2b_data_spacing", a2 - a1, 11);
    send(1'b0, 8'h01, a3);
    chk("after_data_spacing", a3 - a2, 11);
    send(1'b0, 8'h80, a4);
    chk("after_clear_spacing", a4 - a3, 16);
    send(1'b1, 8'h41, a5);
    chk("after_cmd80_spacing", a5 - a4, 11);
    req_valid = 1'b0;

    // Reset during the second EN-high cycle.
    wait_ready();
    send(1'b1, 8'h33, a);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !lcd_en; i++) @(negedge clk);
    @(negedge clk);
    chk("mid_pulse_en_high", int'(lcd_en), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_pulse_rst_en", int'(lcd_en), 0);
    chk("mid_pulse_rst_done", int'(init_done), 0);
    repeat (2) @(negedge clk);
    release_and_init(rel);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("rw_always_low", rw_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
